// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard control for the in-order pipeline.
// Tracks {valid, rd, regwrite, isload} for the NSTAGES stages after decode
// and derives operand forwarding selects, a load-use stall and a redirect
// flush for the decode-stage instruction. Keeps saturating stall/flush/retire
// counters.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   id_valid_i                    decode stage holds a real instruction
//   id_rs1_i/id_rs2_i             decode source registers
//   id_use_rs1_i/id_use_rs2_i     source register actually read
//   id_rd_i, id_regwrite_i        decode destination and write enable
//   id_isload_i                   decode instruction is a load
//   redirect_i                    instruction at RESOLVE_STAGE redirects
//   stall_o, flush_o              hold IF/ID + bubble into EX / kill younger
//   fwd_rs1_o, fwd_rs2_o          0 = register file, k = result of stage k
//   stall_cnt_o, flush_cnt_o,
//   retire_cnt_o                  saturating event counters
module hazard_scoreboard #(
  parameter int unsigned NSTAGES       = 3,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned LOAD_STAGE    = 2,
  parameter int unsigned RESOLVE_STAGE = 2,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FW            = $clog2(NSTAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_isload_i,
  input  logic              redirect_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [FW-1:0]     fwd_rs1_o,
  output logic [FW-1:0]     fwd_rs2_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  // Per-stage record; index 1 = EX.
  logic              ent_valid [1:NSTAGES];
  logic [REG_AW-1:0] ent_rd    [1:NSTAGES];
  logic              ent_rw    [1:NSTAGES];
  logic              ent_ld    [1:NSTAGES];

  logic              hit1, hit2;
  logic              blk1, blk2;
  logic [FW-1:0]     fwd1, fwd2;
  logic              issue;

  // Youngest matching entry decides each source; x0 never matches.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    blk1 = 1'b0;
    blk2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 1; k <= int'(NSTAGES); k++) begin
      if (!hit1 && id_use_rs1_i && (id_rs1_i != '0) && ent_valid[k] &&
          ent_rw[k] && (ent_rd[k] == id_rs1_i)) begin
        hit1 = 1'b1;
        fwd1 = FW'(k);
        blk1 = ent_ld[k] && (k < int'(LOAD_STAGE));
      end
      if (!hit2 && id_use_rs2_i && (id_rs2_i != '0) && ent_valid[k] &&
          ent_rw[k] && (ent_rd[k] == id_rs2_i)) begin
        hit2 = 1'b1;
        fwd2 = FW'(k);
        blk2 = ent_ld[k] && (k < int'(LOAD_STAGE));
      end
    end
  end

  // Flush wins over stall.
  assign stall_o   = id_valid_i && (blk1 || blk2) && !redirect_i;
  assign flush_o   = redirect_i;
  assign fwd_rs1_o = fwd1;
  assign fwd_rs2_o = fwd2;
  assign issue     = id_valid_i && !stall_o && !flush_o;

  // Stage shift; on redirect the entries landing in 2..RESOLVE_STAGE are
  // younger than the redirecting instruction and are killed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 1; k <= int'(NSTAGES); k++) begin
        ent_valid[k] <= 1'b0;
        ent_rd[k]    <= '0;
        ent_rw[k]    <= 1'b0;
        ent_ld[k]    <= 1'b0;
      end
    end else begin
      ent_valid[1] <= issue;
      ent_rd[1]    <= id_rd_i;
      ent_rw[1]    <= id_regwrite_i;
      ent_ld[1]    <= id_isload_i;
      for (int k = 2; k <= int'(NSTAGES); k++) begin
        ent_valid[k] <= ent_valid[k-1] &&
                        !(redirect_i && (k <= int'(RESOLVE_STAGE)));
        ent_rd[k]    <= ent_rd[k-1];
        ent_rw[k]    <= ent_rw[k-1];
        ent_ld[k]    <= ent_ld[k-1];
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_o && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
      if (ent_valid[NSTAGES] && (retire_cnt_o != '1)) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two configurations (3-stage defaults and a 5-stage
// LOAD_STAGE=3 sweep) share the same decode stream. Expectations come from
// a timeline model: every issued instruction remembers its decode cycle, so
// its stage is simply (now - issue cycle).
module tb_hazard_scoreboard;

  localparam int CFG_N [2] = '{3, 5};
  localparam int CFG_L [2] = '{2, 3};
  localparam int CFG_R [2] = '{2, 3};
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use1, id_use2, id_rw, id_ld, redir;

  logic       stall0, flush0, stall1, flush1;
  logic [1:0] f1_0, f2_0;
  logic [2:0] f1_1, f2_1;
  logic [3:0] sc0, fc0, rc0, sc1, fc1, rc1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGES(3), .REG_AW(5), .LOAD_STAGE(2),
                      .RESOLVE_STAGE(2), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
    .id_rd_i(id_rd), .id_regwrite_i(id_rw), .id_isload_i(id_ld),
    .redirect_i(redir), .stall_o(stall0), .flush_o(flush0),
    .fwd_rs1_o(f1_0), .fwd_rs2_o(f2_0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0), .retire_cnt_o(rc0));

  hazard_scoreboard #(.NSTAGES(5), .REG_AW(5), .LOAD_STAGE(3),
                      .RESOLVE_STAGE(3), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
    .id_rd_i(id_rd), .id_regwrite_i(id_rw), .id_isload_i(id_ld),
    .redirect_i(redir), .stall_o(stall1), .flush_o(flush1),
    .fwd_rs1_o(f1_1), .fwd_rs2_o(f2_1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1), .retire_cnt_o(rc1));

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [2:0] f1;
    logic [2:0] f2;
    logic [3:0] sc;
    logic [3:0] fc;
    logic [3:0] rc;
  } exp_t;

  typedef struct {
    int         mid;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    int         issue;
    bit         killed;
  } rec_t;

  exp_t exp_q[$];
  rec_t recs[$];
  int   cyc;
  int   scnt [2];
  int   fcnt [2];
  int   rcnt [2];
  bit   mstall [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Youngest live writer of s in model m; blocked if it is a load too young.
  function automatic void resolve(input int m, input logic [4:0] s,
                                  input logic u, output int fwd, output bit blk);
    int   best;
    logic bld;
    best = 0;
    bld  = 1'b0;
    if (u && s != 5'd0) begin
      foreach (recs[i]) begin
        int st;
        st = cyc - recs[i].issue;
        if (recs[i].mid == m && !recs[i].killed && st >= 1 && st <= CFG_N[m] &&
            recs[i].rw && recs[i].rd == s && (best == 0 || st < best)) begin
          best = st;
          bld  = recs[i].ld;
        end
      end
    end
    fwd = best;
    blk = (best != 0) && bld && (best < CFG_L[m]);
  endfunction

  function automatic void model_reset();
    recs.delete();
    for (int m = 0; m < 2; m++) begin
      scnt[m] = 0; fcnt[m] = 0; rcnt[m] = 0; mstall[m] = 1'b0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  function automatic void model_clock();
    for (int m = 0; m < 2; m++) begin
      bit ret;
      ret = 1'b0;
      foreach (recs[i]) begin
        int st;
        st = cyc - recs[i].issue;
        if (recs[i].mid == m && !recs[i].killed) begin
          if (st == CFG_N[m]) ret = 1'b1;
          if (redir && st >= 1 && st < CFG_R[m]) recs[i].killed = 1'b1;
        end
      end
      if (id_valid && !mstall[m] && !redir)
        recs.push_back('{mid: m, rd: id_rd, rw: id_rw, ld: id_ld,
                         issue: cyc, killed: 1'b0});
      if (ret && rcnt[m] < CMAX) rcnt[m]++;
      if (mstall[m] && scnt[m] < CMAX) scnt[m]++;
      if (redir && fcnt[m] < CMAX) fcnt[m]++;
    end
    cyc++;
    for (int i = recs.size() - 1; i >= 0; i--)
      if (cyc - recs[i].issue > 8) recs.delete(i);
  endfunction

  // One cycle: clock the model, then drive new inputs and queue expectations.
  task automatic step(input logic rn, input logic v, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic rdr);
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
    rst_n    = rn;
    id_valid = v;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_use1  = u1;
    id_use2  = u2;
    id_rd    = rd;
    id_rw    = rw;
    id_ld    = ld;
    redir    = rn ? rdr : 1'b0;
    if (!rn) model_reset();
    for (int m = 0; m < 2; m++) begin
      int   a, b;
      bit   ba, bb;
      exp_t e;
      resolve(m, rs1, u1, a, ba);
      resolve(m, rs2, u2, b, bb);
      mstall[m] = v && (ba || bb) && !redir;
      e.stall = mstall[m];
      e.flush = redir;
      e.f1    = 3'(a);
      e.f2    = 3'(b);
      e.sc    = 4'(scnt[m]);
      e.fc    = 4'(fcnt[m]);
      e.rc    = 4'(rcnt[m]);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation pair per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t a, b;
    if (exp_q.size() >= 2) begin
      a = exp_q.pop_front();
      b = exp_q.pop_front();
      chk("n3_stall", int'(stall0), int'(a.stall));
      chk("n3_flush", int'(flush0), int'(a.flush));
      chk("n3_fwd1",  int'(f1_0),   int'(a.f1));
      chk("n3_fwd2",  int'(f2_0),   int'(a.f2));
      chk("n3_scnt",  int'(sc0),    int'(a.sc));
      chk("n3_fcnt",  int'(fc0),    int'(a.fc));
      chk("n3_rcnt",  int'(rc0),    int'(a.rc));
      chk("n5_stall", int'(stall1), int'(b.stall));
      chk("n5_flush", int'(flush1), int'(b.flush));
      chk("n5_fwd1",  int'(f1_1),   int'(b.f1));
      chk("n5_fwd2",  int'(f2_1),   int'(b.f2));
      chk("n5_scnt",  int'(sc1),    int'(b.sc));
      chk("n5_fcnt",  int'(fc1),    int'(b.fc));
      chk("n5_rcnt",  int'(rc1),    int'(b.rc));
    end
  end

  initial begin
    cyc = 0;
    model_reset();
    rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use1 = 1'b0; id_use2 = 1'b0; id_rw = 1'b0; id_ld = 1'b0; redir = 1'b0;

    // Reset, then back-to-back ALU dependence on x5.
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1'b1, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step(1'b1, 1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    step(1'b1, 1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    idle(4);

    // Load-use on x6: decode held until the stall clears.
    step(1'b1, 1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1, 5'd0, 5'd6, 0, 1, 5'd8, 1, 0, 0);
    idle(6);

    // Youngest-wins on x7, then x0 never hazards.
    step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0);
    idle(1);
    step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0);
    step(1'b1, 1, 5'd7, 5'd7, 1, 1, 5'd0, 0, 0, 0);
    step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
    step(1'b1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
    idle(6);

    // Redirect coinciding with a pending load-use.
    step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 1, 0);
    step(1'b1, 1, 5'd6, 5'd0, 1, 0, 5'd9, 1, 0, 1);
    step(1'b1, 1, 5'd6, 5'd9, 1, 1, 5'd0, 0, 0, 0);
    idle(6);

    // Retire saturation: 20 non-stalling instructions.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd3, 0, 0, 0);
    idle(6);

    // Reset asserted during a load-use stall.
    step(1'b1, 1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0);
    step(1'b1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    step(1'b0, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    step(1'b1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      logic rn;
      rn = ($urandom_range(0, 199) != 0);
      step(rn, ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
